addr_latch_bank: RTL
====================

# addr_latch_bank

Clocked, parametrised successor to the FSMC testbench's discrete transparent address latch. It demultiplexes the address phase of a muxed FSMC AD bus into NCH per-chip-select address registers and holds the captured address after the latch strobe drops. It advances the held address on each data beat, in linear or wrapping-burst mode. It sits in the FSMC verification environment between the AD bus and the memory models, replacing free-running combinational latches with a sampled, resettable model.

## Interface
- DW, 16: address/data width of d and q.
- NCH, 4: number of chip-select channels (≥1).
- BURST_LEN, 4: wrap boundary in beats (power of 2, ≥2, ≤2^DW).
- CW, max(1,$clog2(NCH)): derived channel-index width.

Ports:
- hclk  in  1  clock; all state updates on rising edge.
- hresetn  in  1  reset, asynchronous assert, active-low.
- oe_n  in  1  output enable, active-low; combinational, not sampled.
- latch_en  in  1  latch enable, active-high; sampled on hclk.
- cs_n  in  NCH  chip selects, active-low; exactly one low for a legal capture.
- d  in  DW  AD bus input.
- beat  in  1  one-cycle pulse advancing held address.
- burst_en  in  1  wrap mode select; sampled on the TRACK→HOLD transition.
- q  out  DW  tri-state: addr[act_ch] when oe_n=0, else all-Z.
- act_ch  out  CW  active/last-used channel index.
- valid  out  1  held address valid (HOLD state).
- err  out  1  one-cycle pulse on illegal chip-select at capture.

## Operation
- Storage: addr[0..NCH-1] (DW bits each), act_ch, wrap flag, FSM {IDLE, TRACK, HOLD}.
- IDLE: valid=0. If latch_en=1 and exactly one cs_n bit low (index k): addr[k]<=d, act_ch<=k, go TRACK. If latch_en=1 and zero or multiple cs_n low: no write, err=1 for one cycle, stay IDLE.
- TRACK (transparent): valid=0.
  - latch_en=1 and cs_n[act_ch] still the only low bit: addr[act_ch]<=d every cycle.
  - latch_en=0: go HOLD. The held value is the last d sampled with latch_en=1. wrap<=burst_en.
  - cs_n changes (another bit low, or act_ch high): abort to IDLE. addr keeps its last sample. No err.
- HOLD: valid=1.
  - beat=1, wrap=0: addr[act_ch] <= addr+1 mod 2^DW.
  - beat=1, wrap=1: the low log2(BURST_LEN) bits increment mod BURST_LEN; upper bits unchanged.
  - latch_en=1 with a legal cs: new capture, go TRACK (may switch channel). latch_en wins over a simultaneous beat; the beat is dropped.
  - latch_en=1 with an illegal cs: err pulse, go IDLE.
  - cs_n[act_ch] goes high (latch_en=0): go IDLE. addr and act_ch retained.
- Non-active channels never change except by their own capture.
- q follows addr[act_ch] in all states, including IDLE. oe_n gates q combinationally (Z when high).
- Reset (hresetn=0): all addr=0, act_ch=0, wrap=0, state IDLE, valid=0, err=0. With oe_n=0, q=0 during reset.

## Timing
- Capture latency: d sampled at edge N (latch_en=1) appears on q after edge N.
- valid rises after the first edge that samples latch_en=0 in TRACK. It falls after the edge that samples cs release or a new latch_en.
- Beat increment is visible on q after the sampling edge. Back-to-back beats increment every cycle.
- err is a registered pulse, high exactly one cycle after the offending edge.
- oe_n→q has zero-cycle, combinational effect.
- Asynchronous reset mid-TRACK/HOLD forces IDLE and clears all registers immediately. First capture is possible on the first edge after release.

## Test plan
- Reset: hresetn=0, oe_n=0 → q=0x0000, valid=0, act_ch=0, err=0. Then oe_n=1 → q=Z.
- Linear hold: cs_n=4'b1101, latch_en=1 for d=0x1230 then 0x1234, latch_en=0, burst_en=0 → valid=1, act_ch=1, q=0x1234. 3 beats → 0x1237. Wrap at 0xFFFF+1 → 0x0000.
- Wrap burst: capture 0x00A6 on ch2 with burst_en=1, 4 beats → q=0x00A7, 0x00A4, 0x00A5, 0x00A6.
- Channel retention: capture ch0=0x1111, release, capture ch3=0x3333 → act_ch=3, q=0x3333, addr[0] still 0x1111.
- Illegal select: latch_en=1, cs_n=4'b1100 → err pulse 1 cycle, no register change, state IDLE, valid=0.
- Priority/reset: in HOLD, beat and latch_en (d=0x5555) on the same edge → q=0x5555, no increment. Assert hresetn mid-burst → q=0 immediately.

Source files
------------

// File: rtl/addr_latch_bank_if.sv
// addr_latch_bank_if: groups the FSMC address-phase controls and latch status of addr_latch_bank.
// Signals: oe_n, latch_en, cs_n[NCH], d[DW], beat, burst_en (master->slave);
//          act_ch[CW], valid, err (slave->master). The tri-state q bus lives outside this bundle.
interface addr_latch_bank_if #(
  parameter int DW  = 16,
  parameter int NCH = 4,
  parameter int CW  = (NCH > 1) ? $clog2(NCH) : 1
);
  logic           oe_n;
  logic           latch_en;
  logic [NCH-1:0] cs_n;
  logic [DW-1:0]  d;
  logic           beat;
  logic           burst_en;
  logic [CW-1:0]  act_ch;
  logic           valid;
  logic           err;

  modport master (
    output oe_n, latch_en, cs_n, d, beat, burst_en,
    input  act_ch, valid, err
  );

  modport slave (
    input  oe_n, latch_en, cs_n, d, beat, burst_en,
    output act_ch, valid, err
  );
endinterface

// File: rtl/addr_latch_bank.sv
// addr_latch_bank: demuxes the address phase of a muxed AD bus into NCH per-chip-select
// registers, holds the captured address and advances it per data beat (linear or wrapping).
// Ports: hclk, hresetn (async active-low), bus (slave modport), q (tri-state, gated by oe_n).
module addr_latch_bank #(
  parameter int DW        = 16,
  parameter int NCH       = 4,
  parameter int BURST_LEN = 4,
  parameter int CW        = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic            hclk,
  input  logic            hresetn,
  addr_latch_bank_if.slave bus,
  // q is a tri-state driver, so it is kept as a plain net rather than an interface member
  output logic [DW-1:0]   q
);

  // Bits that roll over inside a wrapping burst; the rest stay fixed.
  localparam logic [DW-1:0] LOW_MASK = DW'(BURST_LEN - 1);

  typedef enum logic [1:0] {IDLE, TRACK, HOLD} state_t;

  state_t         state, state_nxt;
  logic [DW-1:0]  addr [NCH];
  logic [CW-1:0]  act_ch, act_nxt;
  logic           wrap, wrap_nxt;
  logic           err_q, err_nxt;

  logic           wr_en;
  logic [CW-1:0]  wr_ch;
  logic [DW-1:0]  wr_dat;

  logic [NCH-1:0] sel;
  logic [CW-1:0]  sel_idx;
  logic           cs_legal, cs_same;
  logic [DW-1:0]  cur, inc_lin, inc_wrap;

  // Exactly one chip select low <=> active-high vector is a nonzero power of two.
  assign sel      = ~bus.cs_n;
  assign cs_legal = (sel != '0) && ((sel & (sel - NCH'(1))) == '0);

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < NCH; i++) begin
      if (sel[i]) sel_idx = CW'(i);
    end
  end

  assign cs_same  = cs_legal && (sel_idx == act_ch);
  assign cur      = addr[act_ch];
  assign inc_lin  = cur + DW'(1);
  assign inc_wrap = (cur & ~LOW_MASK) | (inc_lin & LOW_MASK);

  always_comb begin
    state_nxt = state;
    act_nxt   = act_ch;
    wrap_nxt  = wrap;
    err_nxt   = 1'b0;
    wr_en     = 1'b0;
    wr_ch     = act_ch;
    wr_dat    = bus.d;
    case (state)
      IDLE: begin
        if (bus.latch_en) begin
          if (cs_legal) begin
            wr_en     = 1'b1;
            wr_ch     = sel_idx;
            act_nxt   = sel_idx;
            state_nxt = TRACK;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      TRACK: begin
        // Strobe drop freezes the last sample; any select change aborts silently.
        if (!bus.latch_en) begin
          state_nxt = HOLD;
          wrap_nxt  = bus.burst_en;
        end else if (cs_same) begin
          wr_en = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      HOLD: begin
        // A new strobe outranks a coincident beat; the beat is lost.
        if (bus.latch_en) begin
          if (cs_legal) begin
            wr_en     = 1'b1;
            wr_ch     = sel_idx;
            act_nxt   = sel_idx;
            state_nxt = TRACK;
          end else begin
            err_nxt   = 1'b1;
            state_nxt = IDLE;
          end
        end else if (bus.cs_n[act_ch]) begin
          state_nxt = IDLE;
        end else if (bus.beat) begin
          wr_en  = 1'b1;
          wr_dat = wrap ? inc_wrap : inc_lin;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state  <= IDLE;
      act_ch <= '0;
      wrap   <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      act_ch <= act_nxt;
      wrap   <= wrap_nxt;
      err_q  <= err_nxt;
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      for (int i = 0; i < NCH; i++) addr[i] <= '0;
    end else if (wr_en) begin
      addr[wr_ch] <= wr_dat;
    end
  end

  assign bus.act_ch = act_ch;
  assign bus.valid  = (state == HOLD);
  assign bus.err    = err_q;
  assign q          = bus.oe_n ? {DW{1'bz}} : cur;

endmodule
